// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the writeback side of the core.
// Holds the default datapath widths, the writeback-source and load-type
// codes carried down the pipe from MEM, and the WB stage state encoding.
package pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  // Writeback data source selector (mem_wdsel)
  localparam logic [1:0] WDSEL_ALU  = 2'b00;
  localparam logic [1:0] WDSEL_LOAD = 2'b01;
  localparam logic [1:0] WDSEL_PC4  = 2'b10;
  localparam logic [1:0] WDSEL_RSVD = 2'b11;

  // Load type (mem_dmtype); unlisted codes behave as a full word load
  localparam logic [2:0] DMTYPE_LW  = 3'b000;
  localparam logic [2:0] DMTYPE_LH  = 3'b001;
  localparam logic [2:0] DMTYPE_LHU = 3'b010;
  localparam logic [2:0] DMTYPE_LB  = 3'b011;
  localparam logic [2:0] DMTYPE_LBU = 3'b100;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'b00,
    WB_WRITE = 2'b01,
    WB_WAIT  = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext: combinational load-data aligner / extender.
// Picks the addressed byte or halfword out of the memory read word and
// sign- or zero-extends it according to the load type.
// Ports:
//   rdata   in  XLEN  raw data-memory read word
//   addr_lo in  2     byte offset of the load address
//   dmtype  in  3     load type code (DMTYPE_*)
//   ext     out XLEN  aligned, extended result
module load_ext
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      dmtype,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection. Halfwords only use addr_lo[1]; a misaligned offset
  // simply falls back onto the enclosing aligned halfword.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext = rdata;
    case (dmtype)
      DMTYPE_LB:  ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      DMTYPE_LBU: ext = {{(XLEN-8){1'b0}}, byte_sel};
      DMTYPE_LH:  ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      DMTYPE_LHU: ext = {{(XLEN-16){1'b0}}, half_sel};
      default:    ext = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage, producer side of the register-file write port.
// Holds the MEM/WB register, waits for multi-cycle load responses, extends
// load data and emits exactly one registered write slot per retired
// instruction. Also reports the destination of an outstanding load.
// Ports:
//   clk, rst                      clock, async active-high reset
//   mem_valid / mem_ready         MEM->WB handshake
//   mem_rfwr, mem_rd, mem_wdsel   write enable, destination, data source
//   mem_dmtype, mem_addr_lo       load type and byte offset
//   mem_alu, mem_pc4              ALU result and PC+4
//   dm_rvalid, dm_rdata           data-memory read response
//   RFWr, A3, WD                  registered register-file write port
//   ld_pending, ld_rd             outstanding load and its destination
//   dm_err                        sticky: read response arrived unexpectedly
//   retire_cnt                    count of write slots (wraps)
module wb_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_rfwr,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [1:0]        mem_wdsel,
  input  logic [2:0]        mem_dmtype,
  input  logic [XLEN-1:0]   mem_alu,
  input  logic [XLEN-1:0]   mem_pc4,
  input  logic [1:0]        mem_addr_lo,
  input  logic              dm_rvalid,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic              RFWr,
  output logic [REG_AW-1:0] A3,
  output logic [XLEN-1:0]   WD,
  output logic              ld_pending,
  output logic [REG_AW-1:0] ld_rd,
  output logic              dm_err,
  output logic [31:0]       retire_cnt
);

  wb_state_e       state;
  logic            ld_rfwr;
  logic [2:0]      ld_dmtype;
  logic [1:0]      ld_addr_lo;
  logic [XLEN-1:0] ld_data;
  logic            accept;

  // ld_rd doubles as the latched destination of the outstanding load,
  // so only the remaining load attributes need their own registers.
  load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata   (dm_rdata),
    .addr_lo (ld_addr_lo),
    .dmtype  (ld_dmtype),
    .ext     (ld_data)
  );

  assign mem_ready = ~rst & (state != WB_WAIT);
  assign accept    = mem_valid & mem_ready;

  // Single FSM with registered write port. A slot is the cycle following
  // the edge that entered WRITE; A3/WD keep their last values outside slots
  // so a suppressed write (rd=0 or rfwr=0) still shows what retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WB_IDLE;
      RFWr       <= 1'b0;
      A3         <= '0;
      WD         <= '0;
      ld_pending <= 1'b0;
      ld_rd      <= '0;
      ld_rfwr    <= 1'b0;
      ld_dmtype  <= DMTYPE_LW;
      ld_addr_lo <= 2'b00;
      dm_err     <= 1'b0;
      retire_cnt <= 32'd0;
    end else begin
      if (dm_rvalid && (state != WB_WAIT)) begin
        dm_err <= 1'b1;
      end
      case (state)
        WB_WAIT: begin
          if (dm_rvalid) begin
            state      <= WB_WRITE;
            RFWr       <= ld_rfwr & (ld_rd != '0);
            A3         <= ld_rd;
            WD         <= ld_data;
            retire_cnt <= retire_cnt + 32'd1;
            ld_pending <= 1'b0;
            ld_rd      <= '0;
          end
        end
        default: begin
          RFWr <= 1'b0;
          if (accept) begin
            if (mem_wdsel == WDSEL_LOAD) begin
              state      <= WB_WAIT;
              ld_pending <= 1'b1;
              ld_rd      <= mem_rd;
              ld_rfwr    <= mem_rfwr;
              ld_dmtype  <= mem_dmtype;
              ld_addr_lo <= mem_addr_lo;
            end else begin
              state      <= WB_WRITE;
              RFWr       <= mem_rfwr & (mem_rd != '0);
              A3         <= mem_rd;
              WD         <= (mem_wdsel == WDSEL_PC4) ? mem_pc4 : mem_alu;
              retire_cnt <= retire_cnt + 32'd1;
            end
          end else begin
            state <= WB_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of instructions with expected write-port values,
// a scoreboard queue filled on issue and drained whenever a write slot
// appears, plus hand-written reset, stray-response and counter-wrap cases.
module tb_wb_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_rfwr = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [1:0]  mem_wdsel = '0;
  logic [2:0]  mem_dmtype = '0;
  logic [31:0] mem_alu = '0;
  logic [31:0] mem_pc4 = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        ld_pending;
  logic [4:0]  ld_rd;
  logic        dm_err;
  logic [31:0] retire_cnt;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rfwr(mem_rfwr), .mem_rd(mem_rd), .mem_wdsel(mem_wdsel),
    .mem_dmtype(mem_dmtype), .mem_alu(mem_alu), .mem_pc4(mem_pc4),
    .mem_addr_lo(mem_addr_lo), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .RFWr(RFWr), .A3(A3), .WD(WD),
    .ld_pending(ld_pending), .ld_rd(ld_rd), .dm_err(dm_err),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rfwr;
    logic [4:0]  rd;
    logic [1:0]  wdsel;
    logic [2:0]  dmtype;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [1:0]  addr_lo;
    logic [31:0] rdata;
    int          lat;
    logic        exp_rfwr;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    logic        rfwr;
    logic [4:0]  a3;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[13];
  int          total = 0;
  int          bad = 0;
  logic [31:0] prev_cnt = '0;
  logic [31:0] exp_cnt = '0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drain one scoreboard entry whenever the DUT shows a write slot.
  task automatic checkOutput();
    exp_t e;
    if ((retire_cnt != prev_cnt) || RFWr) begin
      if (sb.size() == 0) begin
        checkVal("unexpected_slot", {31'd0, RFWr}, 32'd0);
      end else begin
        e = sb.pop_front();
        exp_cnt = exp_cnt + 32'd1;
        checkVal("RFWr", {31'd0, RFWr}, {31'd0, e.rfwr});
        checkVal("A3", {27'd0, A3}, {27'd0, e.a3});
        checkVal("WD", WD, e.wd);
        checkVal("retire_cnt", retire_cnt, exp_cnt);
      end
    end
    prev_cnt = retire_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    mem_valid = 1'b0;
    dm_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    checkVal("rst_RFWr", {31'd0, RFWr}, 32'd0);
    checkVal("rst_A3", {27'd0, A3}, 32'd0);
    checkVal("rst_WD", WD, 32'd0);
    checkVal("rst_ld_pending", {31'd0, ld_pending}, 32'd0);
    checkVal("rst_ld_rd", {27'd0, ld_rd}, 32'd0);
    checkVal("rst_dm_err", {31'd0, dm_err}, 32'd0);
    checkVal("rst_retire_cnt", retire_cnt, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_cnt = '0;
    exp_cnt = '0;
    tick();
    checkVal("ready_after_rst", {31'd0, mem_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    mem_valid   = 1'b1;
    mem_rfwr    = v.rfwr;
    mem_rd      = v.rd;
    mem_wdsel   = v.wdsel;
    mem_dmtype  = v.dmtype;
    mem_alu     = v.alu;
    mem_pc4     = v.pc4;
    mem_addr_lo = v.addr_lo;
    e.rfwr = v.exp_rfwr;
    e.a3   = v.rd;
    e.wd   = v.exp_wd;
    sb.push_back(e);
    if (v.wdsel == WDSEL_LOAD) begin
      tick();
      mem_valid = 1'b0;
      dm_rdata  = 32'hA5A5_5A5A;
      for (int i = 1; i < v.lat; i++) begin
        checkVal("wait_ready", {31'd0, mem_ready}, 32'd0);
        checkVal("wait_ld_pending", {31'd0, ld_pending}, 32'd1);
        checkVal("wait_ld_rd", {27'd0, ld_rd}, {27'd0, v.rd});
        tick();
      end
      dm_rvalid = 1'b1;
      dm_rdata  = v.rdata;
      tick();
      dm_rvalid = 1'b0;
      checkVal("ld_pending_clr", {31'd0, ld_pending}, 32'd0);
    end else begin
      tick();
    end
    checkVal("slot_seen", 32'(sb.size()), 32'd0);
  endtask

  function automatic vec_t mk(input logic rfwr, input logic [4:0] rd, input logic [1:0] wdsel,
                              input logic [2:0] dmtype, input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [1:0] addr_lo, input logic [31:0] rdata, input int lat,
                              input logic exp_rfwr, input logic [31:0] exp_wd);
    vec_t v;
    v.rfwr = rfwr; v.rd = rd; v.wdsel = wdsel; v.dmtype = dmtype;
    v.alu = alu; v.pc4 = pc4; v.addr_lo = addr_lo; v.rdata = rdata;
    v.lat = lat; v.exp_rfwr = exp_rfwr; v.exp_wd = exp_wd;
    return v;
  endfunction

  initial begin
    vec_t w;
    vecs[0]  = mk(1, 5'd5,  WDSEL_ALU,  DMTYPE_LW,  32'h11,   32'h0,   2'd0, 32'h0,        0, 1, 32'h11);
    vecs[1]  = mk(1, 5'd6,  WDSEL_ALU,  DMTYPE_LW,  32'h22,   32'h0,   2'd0, 32'h0,        0, 1, 32'h22);
    vecs[2]  = mk(1, 5'd7,  WDSEL_LOAD, DMTYPE_LB,  32'h1002, 32'h0,   2'd2, 32'h0080FF00, 3, 1, 32'hFFFFFF80);
    vecs[3]  = mk(1, 5'd7,  WDSEL_LOAD, DMTYPE_LHU, 32'h1002, 32'h0,   2'd2, 32'h0080FF00, 3, 1, 32'h00000080);
    vecs[4]  = mk(1, 5'd7,  WDSEL_LOAD, DMTYPE_LH,  32'h1000, 32'h0,   2'd0, 32'h0080FF00, 3, 1, 32'hFFFFFF00);
    vecs[5]  = mk(1, 5'd0,  WDSEL_PC4,  DMTYPE_LW,  32'h500,  32'h104, 2'd0, 32'h0,        0, 0, 32'h104);
    vecs[6]  = mk(0, 5'd0,  WDSEL_ALU,  DMTYPE_LW,  32'h200,  32'h108, 2'd0, 32'h0,        0, 0, 32'h200);
    vecs[7]  = mk(1, 5'd9,  WDSEL_LOAD, DMTYPE_LBU, 32'h3,    32'h0,   2'd3, 32'hAB000000, 1, 1, 32'h000000AB);
    vecs[8]  = mk(1, 5'd10, WDSEL_LOAD, DMTYPE_LW,  32'h1,    32'h0,   2'd1, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF);
    vecs[9]  = mk(1, 5'd11, WDSEL_RSVD, DMTYPE_LW,  32'h33,   32'h99,  2'd0, 32'h0,        0, 1, 32'h33);
    vecs[10] = mk(1, 5'd12, WDSEL_LOAD, 3'b111,     32'h0,    32'h0,   2'd2, 32'h12345678, 2, 1, 32'h12345678);
    vecs[11] = mk(1, 5'd13, WDSEL_LOAD, DMTYPE_LB,  32'h1,    32'h0,   2'd1, 32'h00007F00, 1, 1, 32'h0000007F);
    vecs[12] = mk(1, 5'd14, WDSEL_LOAD, DMTYPE_LH,  32'h3,    32'h0,   2'd3, 32'h80010000, 2, 1, 32'hFFFF8001);

    doReset();

    $display("[TB] reset in the middle of a write slot");
    applyStimulus(mk(1, 5'd3, WDSEL_ALU, DMTYPE_LW, 32'hAA, 32'h0, 2'd0, 32'h0, 0, 1, 32'hAA));
    doReset();

    $display("[TB] instruction table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
    end
    mem_valid = 1'b0;
    tick();
    checkVal("idle_RFWr", {31'd0, RFWr}, 32'd0);
    checkVal("idle_retire_cnt", retire_cnt, 32'd13);

    $display("[TB] stray read response in IDLE");
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hFFFF_FFFF;
    tick();
    dm_rvalid = 1'b0;
    tick();
    checkVal("stray_dm_err", {31'd0, dm_err}, 32'd1);
    checkVal("stray_RFWr", {31'd0, RFWr}, 32'd0);
    checkVal("stray_retire_cnt", retire_cnt, 32'd13);

    $display("[TB] retire counter wrap");
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    prev_cnt = 32'hFFFF_FFFF;
    exp_cnt  = 32'hFFFF_FFFF;
    applyStimulus(mk(1, 5'd4, WDSEL_ALU, DMTYPE_LW, 32'h55, 32'h0, 2'd0, 32'h0, 0, 1, 32'h55));
    mem_valid = 1'b0;
    checkVal("wrap_retire_cnt", retire_cnt, 32'd0);
    checkVal("dm_err_sticky", {31'd0, dm_err}, 32'd1);
    tick();

    $display("[TB] reset while waiting for a load");
    doReset();
    w = mk(1, 5'd8, WDSEL_LOAD, DMTYPE_LW, 32'h0, 32'h0, 2'd0, 32'h0, 0, 1, 32'h0);
    mem_valid = 1'b1; mem_rfwr = w.rfwr; mem_rd = w.rd; mem_wdsel = w.wdsel;
    mem_dmtype = w.dmtype; mem_addr_lo = w.addr_lo;
    tick();
    mem_valid = 1'b0;
    checkVal("pre_rst_ld_pending", {31'd0, ld_pending}, 32'd1);
    checkVal("pre_rst_ld_rd", {27'd0, ld_rd}, 32'd8);
    tick();
    rst = 1'b1;
    #1;
    checkVal("midwait_ld_pending", {31'd0, ld_pending}, 32'd0);
    checkVal("midwait_ld_rd", {27'd0, ld_rd}, 32'd0);
    #2;
    rst = 1'b0;
    prev_cnt = '0;
    exp_cnt  = '0;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h0BAD_F00D;
    tick();
    dm_rvalid = 1'b0;
    checkVal("late_RFWr", {31'd0, RFWr}, 32'd0);
    checkVal("late_dm_err", {31'd0, dm_err}, 32'd1);
    checkVal("late_ld_pending", {31'd0, ld_pending}, 32'd0);
    checkVal("late_retire_cnt", retire_cnt, 32'd0);
    tick();
    checkVal("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
